ceespu_uart_tx: RTL and testbench

// - Memory-mapped UART transmitter on the ceespu data-memory port.

---
 rtl/ceespu_uart_tx_pkg.sv | 46 ++++
 rtl/ceespu_sync_fifo.sv | 78 +++++++
 rtl/ceespu_uart_tx.sv | 258 +++++++++++++++++++++++++
 tb/tb_ceespu_uart_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceespu_uart_tx_pkg.sv
// ceespu_uart_tx_pkg
// Shared constants for the ceespu UART blocks: register offsets (word index
// taken from dmem address bits [3:2]), STATUS bit positions, the 2-bit
// transmitter state encoding and a helper that packs the STATUS word.
// No ports; imported by ceespu_uart_tx.

package ceespu_uart_tx_pkg;

    // Register word offsets within the 16-byte window
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EMPTY     = 2;
    localparam int STATUS_OVF       = 3;
    localparam int STATUS_COUNT_LSB = 8;

    // Transmitter frame states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } txState_t;

    // Assemble the STATUS read word from its individual fields
    function automatic logic [31:0] packStatus(input logic busy,
                                               input logic full,
                                               input logic empty,
                                               input logic ovf,
                                               input logic [7:0] count);
        logic [31:0] word;
        word = '0;
        word[STATUS_BUSY]                = busy;
        word[STATUS_FULL]                = full;
        word[STATUS_EMPTY]               = empty;
        word[STATUS_OVF]                 = ovf;
        word[STATUS_COUNT_LSB +: 8]      = count;
        return word;
    endfunction

endpackage

// File: rtl/ceespu_sync_fifo.sv
// ceespu_sync_fifo
// Single-clock FIFO with show-ahead read (popData always presents the head).
// Intended for reuse by both the UART transmitter and a future receiver.
// Ports:
//   I_clk     in  1          clock, rising edge
//   I_rst_n   in  1          asynchronous active-low reset, empties the FIFO
//   push      in  1          write pushData (ignored when full unless popping)
//   pushData  in  WIDTH      data to enqueue
//   pop       in  1          remove the head entry (ignored when empty)
//   popData   out WIDTH      current head entry
//   full      out 1          DEPTH entries held
//   empty     out 1          no entries held
//   count     out log2(D)+1  number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.

module ceespu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     I_clk,
    input  logic                     I_rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      countReg;
    logic             doPush;
    logic             doPop;

    assign full    = (countReg == (AW+1)'(DEPTH));
    assign empty   = (countReg == '0);
    assign count   = countReg;
    assign popData = mem[rdPtr];

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle, because the slot it frees is the one being written.
    assign doPush = push & (~full | pop);
    assign doPop  = pop & ~empty;

    // Storage is not reset; validity is tracked purely by the pointers.
    always_ff @(posedge I_clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/ceespu_uart_tx.sv
// ceespu_uart_tx
// Memory-mapped 8N1 UART transmitter on the ceespu data-memory port.
// Software pushes bytes into a TX FIFO; a serialiser drains it at a
// programmable bit period of BAUDDIV+1 clocks.
// Registers (word offsets in a 16-byte window at BASE_ADDR):
//   0x0 TXDATA  write pushes WData[7:0], reads 0
//   0x4 STATUS  [0] busy [1] full [2] empty [3] ovf (write 1 clears) [15:8] count
//   0x8 BAUDDIV [15:0], byte-lane writable
//   0xC CTRL    [0] irq_en, only with CEESPU_UART_IRQ_EN, otherwise reads 0
// Ports:
//   I_clk          in  1   system clock
//   I_rst_n        in  1   asynchronous active-low reset
//   I_dmemAddress  in  16  byte address
//   I_dmemWData    in  32  write data
//   I_dmemE        in  1   access enable
//   I_dmemWe       in  4   byte write enables, 0 means read
//   O_rdata        out 32  registered read data, 0 when not selected
//   O_txd          out 1   registered serial output, idle high
//   O_irq          out 1   registered TX-drained interrupt (CEESPU_UART_IRQ_EN only)
// Macro CEESPU_UART_IRQ_EN adds CTRL and O_irq.

module ceespu_uart_tx
    import ceespu_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hFF00,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [15:0] I_dmemAddress,
    input  logic [31:0] I_dmemWData,
    input  logic        I_dmemE,
    input  logic [3:0]  I_dmemWe,
    output logic [31:0] O_rdata,
    output logic        O_txd
`ifdef CEESPU_UART_IRQ_EN
    ,
    output logic        O_irq
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             sel;
    logic [1:0]       regOffset;
    logic             isWrite;
    logic             txPush;
    logic             ovfClear;
    logic             baudWrLo;
    logic             baudWrHi;

    logic             fifoPop;
    logic [7:0]       fifoData;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [15:0]      countWide;

    logic             ovf;
    logic [15:0]      baudDiv;
    logic [31:0]      readValue;

    txState_t         state;
    txState_t         stateNext;
    logic [15:0]      baudCnt;
    logic [15:0]      baudCntNext;
    logic [2:0]       bitIdx;
    logic [2:0]       bitIdxNext;
    logic [7:0]       shiftReg;
    logic [7:0]       shiftNext;
    logic             txdNext;

    logic             unusedBits;

    // Address decode: one 16-byte window, word offset from bits [3:2]
    assign sel       = I_dmemE & (I_dmemAddress[15:4] == BASE_ADDR[15:4]);
    assign regOffset = I_dmemAddress[3:2];
    assign isWrite   = |I_dmemWe;

    assign txPush   = sel & isWrite & (regOffset == UART_TXDATA) & I_dmemWe[0];
    assign ovfClear = sel & isWrite & (regOffset == UART_STATUS) & I_dmemWe[0]
                      & I_dmemWData[STATUS_OVF];
    assign baudWrLo = sel & (regOffset == UART_BAUDDIV) & I_dmemWe[0];
    assign baudWrHi = sel & (regOffset == UART_BAUDDIV) & I_dmemWe[1];

    assign countWide  = 16'(fifoCount);
    assign unusedBits = ^{I_dmemAddress[1:0], I_dmemWData[31:16], countWide[15:8]};

    ceespu_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .I_clk    (I_clk),
        .I_rst_n  (I_rst_n),
        .push     (txPush),
        .pushData (I_dmemWData[7:0]),
        .pop      (fifoPop),
        .popData  (fifoData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Sticky overflow flag: set only when a byte is actually dropped, i.e.
    // the FIFO is full and the serialiser is not freeing a slot this cycle.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            ovf <= 1'b0;
        end else if (ovfClear) begin
            ovf <= 1'b0;
        end else if (txPush & fifoFull & ~fifoPop) begin
            ovf <= 1'b1;
        end
    end

    // Bit-period divisor; the serialiser samples it only at bit starts, so a
    // write in the middle of a bit takes effect from the following bit.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            baudDiv <= BAUDDIV_RST;
        end else begin
            if (baudWrLo) begin
                baudDiv[7:0] <= I_dmemWData[7:0];
            end
            if (baudWrHi) begin
                baudDiv[15:8] <= I_dmemWData[15:8];
            end
        end
    end

    // Frame state register; O_txd is registered from the next state so the
    // line level always lines up with the state that owns it.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state    <= TX_IDLE;
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            O_txd    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            O_txd    <= txdNext;
        end
    end

    // Next-state logic. Every bit reloads the counter with BAUDDIV and ends
    // when it reaches zero, giving BAUDDIV+1 clocks per bit. IDLE lasts a
    // single cycle between back-to-back frames.
    always_comb begin
        stateNext   = state;
        baudCntNext = baudCnt;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        fifoPop     = 1'b0;

        case (state)
            TX_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop     = 1'b1;
                    shiftNext   = fifoData;
                    baudCntNext = baudDiv;
                    stateNext   = TX_START;
                end
            end
            TX_START: begin
                if (baudCnt == '0) begin
                    baudCntNext = baudDiv;
                    bitIdxNext  = '0;
                    stateNext   = TX_DATA;
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (baudCnt == '0) begin
                    baudCntNext = baudDiv;
                    if (bitIdx == 3'd7) begin
                        stateNext = TX_STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                        shiftNext  = {1'b0, shiftReg[7:1]};
                    end
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (baudCnt == '0) begin
                    stateNext = TX_IDLE;
                end else begin
                    baudCntNext = baudCnt - 16'd1;
                end
            end
            default: begin
                stateNext = TX_IDLE;
            end
        endcase

        case (stateNext)
            TX_START: txdNext = 1'b0;
            TX_DATA:  txdNext = shiftNext[0];
            default:  txdNext = 1'b1;
        endcase
    end

`ifdef CEESPU_UART_IRQ_EN
    logic irqEn;
    logic ctrlWrite;

    assign ctrlWrite = sel & isWrite & (regOffset == UART_CTRL) & I_dmemWe[0];

    // Interrupt enable bit
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            irqEn <= 1'b0;
        end else if (ctrlWrite) begin
            irqEn <= I_dmemWData[0];
        end
    end

    // Level interrupt raised once the transmitter has fully drained
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_irq <= 1'b0;
        end else begin
            O_irq <= irqEn & fifoEmpty & (state == TX_IDLE);
        end
    end
`endif

    // Read mux for the selected register
    always_comb begin
        readValue = '0;
        case (regOffset)
            UART_STATUS:  readValue = packStatus(state != TX_IDLE, fifoFull,
                                                 fifoEmpty, ovf, countWide[7:0]);
            UART_BAUDDIV: readValue = {16'h0000, baudDiv};
`ifdef CEESPU_UART_IRQ_EN
            UART_CTRL:    readValue = {31'h0, irqEn};
`endif
            default:      readValue = '0;
        endcase
    end

    // Registered read port; zero when unselected so the SoC can OR buses
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rdata <= '0;
        end else begin
            O_rdata <= (sel & ~isWrite) ? readValue : '0;
        end
    end

endmodule

// File: tb/tb_ceespu_uart_tx.sv
// tb_ceespu_uart_tx
// Self-checking bench for ceespu_uart_tx. A serial monitor decodes frames on
// O_txd and compares them against a queue of bytes expected to be sent.
// Build with CEESPU_UART_IRQ_EN defined to exercise CTRL and O_irq.

module tb_ceespu_uart_tx;

    localparam logic [15:0] A_TXDATA = 16'hFF00;
    localparam logic [15:0] A_STATUS = 16'hFF04;
    localparam logic [15:0] A_BAUD   = 16'hFF08;
    localparam logic [15:0] A_CTRL   = 16'hFF0C;

    logic        I_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic [15:0] I_dmemAddress = '0;
    logic [31:0] I_dmemWData = '0;
    logic        I_dmemE = 1'b0;
    logic [3:0]  I_dmemWe = '0;
    logic [31:0] O_rdata;
    logic        O_txd;
`ifdef CEESPU_UART_IRQ_EN
    logic        O_irq;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  expQ[$];
    int          bitClks = 434;
    bit          monEnable = 1'b1;

    ceespu_uart_tx dut (
        .I_clk         (I_clk),
        .I_rst_n       (I_rst_n),
        .I_dmemAddress (I_dmemAddress),
        .I_dmemWData   (I_dmemWData),
        .I_dmemE       (I_dmemE),
        .I_dmemWe      (I_dmemWe),
        .O_rdata       (O_rdata),
        .O_txd         (O_txd)
`ifdef CEESPU_UART_IRQ_EN
        ,
        .O_irq         (O_irq)
`endif
    );

    // 100 MHz-style clock
    always #5 I_clk = ~I_clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One bus cycle; read data is sampled just after the capturing edge
    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] we, output logic [31:0] rdata);
        I_dmemAddress = addr;
        I_dmemWData   = wdata;
        I_dmemWe      = we;
        I_dmemE       = 1'b1;
        @(posedge I_clk);
        #1;
        rdata    = O_rdata;
        I_dmemE  = 1'b0;
        I_dmemWe = '0;
    endtask

    task automatic writeReg(input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] we);
        logic [31:0] rd;
        applyStimulus(addr, data, we, rd);
    endtask

    task automatic readCheck(input string tag, input logic [15:0] addr,
                             input logic [31:0] expected);
        logic [31:0] rd;
        applyStimulus(addr, 32'h0, 4'b0000, rd);
        checkOutput(tag, rd, expected);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit expectTx);
        writeReg(A_TXDATA, {24'h0, b}, 4'b0001);
        if (expectTx) begin
            expQ.push_back(b);
        end
    endtask

    // Wait for the monitor to consume every expected byte, then for the
    // line to settle back to idle
    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge I_clk);
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        repeat (2 * bitClks + 4) @(posedge I_clk);
        #1;
    endtask

    // Expected O_txd waveform sampled once per clock: one idle sample, then
    // start, 8 data bits LSB first and stop; the first nFirst elements last
    // pFirst clocks, the rest pRest clocks. Unused tail stays high (idle).
    function automatic logic [127:0] frameWave(input logic [7:0] data, input int pFirst,
                                               input int nFirst, input int pRest);
        logic [127:0] w;
        int pos;
        w   = '1;
        pos = 1;
        for (int j = 0; j < 10; j++) begin
            int   d;
            logic v;
            d = (j < nFirst) ? pFirst : pRest;
            v = (j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : data[j-1]);
            for (int k = 0; k < d; k++) begin
                w[pos] = v;
                pos++;
            end
        end
        return w;
    endfunction

    task automatic captureTxd(input int n, output logic [127:0] obs);
        obs = '1;
        for (int i = 0; i < n; i++) begin
            @(negedge I_clk);
            obs[i] = O_txd;
        end
    endtask

    // Serial monitor: mid-bit sampling of each frame using the bench's own
    // notion of the bit period
    initial begin
        logic       prevTxd;
        logic [7:0] rx;
        int         p;
        prevTxd = 1'b1;
        forever begin
            @(negedge I_clk);
            if (monEnable && I_rst_n && prevTxd && (O_txd == 1'b0)) begin
                p = bitClks;
                repeat (p / 2) @(negedge I_clk);
                checkOutput("startBit", O_txd, 1'b0);
                for (int j = 0; j < 8; j++) begin
                    repeat (p) @(negedge I_clk);
                    rx[j] = O_txd;
                end
                repeat (p) @(negedge I_clk);
                checkOutput("stopBit", O_txd, 1'b1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrame", {120'h0, rx}, 128'h100);
                end else begin
                    checkOutput("rxByte", rx, expQ.pop_front());
                end
            end
            prevTxd = O_txd;
        end
    end

    // Hard time limit
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] obs;
        logic [31:0]  rd;
        logic [7:0]   patterns [4];
        int           highLow;

        patterns[0] = 8'h00;
        patterns[1] = 8'hFF;
        patterns[2] = 8'hA3;
        patterns[3] = 8'h01;

        $display("[TB] reset state");
        repeat (3) @(posedge I_clk);
        #1;
        checkOutput("rstTxd", O_txd, 1'b1);
        checkOutput("rstRdata", O_rdata, 32'h0);
`ifdef CEESPU_UART_IRQ_EN
        checkOutput("rstIrq", O_irq, 1'b0);
`endif
        I_rst_n = 1'b1;
        @(posedge I_clk);
        #1;
        readCheck("rstStatus", A_STATUS, 32'h0000_0004);
        readCheck("rstBaud", A_BAUD, 32'd433);
        readCheck("txdataReads0", A_TXDATA, 32'h0);

        $display("[TB] BAUDDIV byte lanes");
        writeReg(A_BAUD, 32'h0000_0003, 4'b0011);
        readCheck("baudWrite", A_BAUD, 32'h0000_0003);
        writeReg(A_BAUD, 32'h0000_AB07, 4'b0010);
        readCheck("baudHiLane", A_BAUD, 32'h0000_AB03);
        writeReg(A_BAUD, 32'h0000_0003, 4'b0011);
        bitClks = 4;

        $display("[TB] exact frame 0x55");
        sendByte(8'h55, 1'b1);
        captureTxd(42, obs);
        checkOutput("frame55", obs, frameWave(8'h55, 4, 10, 4));
        waitDrain(500);

        $display("[TB] back-to-back patterns");
        foreach (patterns[i]) begin
            sendByte(patterns[i], 1'b1);
        end
        waitDrain(2000);
        readCheck("idleStatus", A_STATUS, 32'h0000_0004);

        $display("[TB] status while busy and decode");
        sendByte(8'h3C, 1'b1);
        repeat (3) @(posedge I_clk);
        #1;
        readCheck("busyStatus", A_STATUS, 32'h0000_0005);
        readCheck("unselected", 16'hFE04, 32'h0);
        applyStimulus(A_STATUS, 32'h0, 4'b0001, rd);
        checkOutput("wrStatusRdata", rd, 32'h0);
        waitDrain(500);

        $display("[TB] FIFO overflow");
        writeReg(A_BAUD, 32'd15, 4'b0011);
        bitClks = 16;
        for (int i = 0; i < 18; i++) begin
            sendByte(8'h10 + 8'(i), i <= 16);
        end
        readCheck("ovfStatus", A_STATUS, 32'h0000_100B);
        writeReg(A_STATUS, 32'h0000_0008, 4'b0001);
        readCheck("ovfCleared", A_STATUS, 32'h0000_1003);
        waitDrain(4000);
        readCheck("postOvfStatus", A_STATUS, 32'h0000_0004);

        $display("[TB] BAUDDIV change mid-frame");
        writeReg(A_BAUD, 32'd3, 4'b0011);
        bitClks = 4;
        monEnable = 1'b0;
        sendByte(8'h96, 1'b0);
        fork
            captureTxd(66, obs);
            begin
                repeat (14) @(negedge I_clk);
                writeReg(A_BAUD, 32'd7, 4'b0011);
            end
        join
        checkOutput("baudChange", obs, frameWave(8'h96, 4, 4, 8));
        repeat (20) @(posedge I_clk);
        #1;
        writeReg(A_BAUD, 32'd3, 4'b0011);

        $display("[TB] reset during DATA");
        sendByte(8'h00, 1'b0);
        sendByte(8'h11, 1'b0);
        repeat (10) @(negedge I_clk);
        I_rst_n = 1'b0;
        #1;
        checkOutput("asyncRstTxd", O_txd, 1'b1);
        repeat (2) @(negedge I_clk);
        I_rst_n = 1'b1;
        bitClks = 434;
        @(posedge I_clk);
        #1;
        readCheck("rstStatusAfter", A_STATUS, 32'h0000_0004);
        readCheck("rstBaudAfter", A_BAUD, 32'd433);
        highLow = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge I_clk);
            if (O_txd !== 1'b1) begin
                highLow++;
            end
        end
        checkOutput("noTxAfterRst", highLow, 0);
        @(posedge I_clk);
        #1;
        monEnable = 1'b1;

        $display("[TB] CTRL register");
        writeReg(A_BAUD, 32'd1, 4'b0011);
        bitClks = 2;
        writeReg(A_CTRL, 32'h1, 4'b0001);
`ifdef CEESPU_UART_IRQ_EN
        readCheck("ctrlReadback", A_CTRL, 32'h1);
        repeat (2) @(posedge I_clk);
        #1;
        checkOutput("irqIdle", O_irq, 1'b1);
        sendByte(8'h5A, 1'b1);
        obs = '1;
        for (int i = 0; i < 25; i++) begin
            @(negedge I_clk);
            obs[i] = O_irq;
        end
        begin
            logic [127:0] expIrq;
            expIrq = '1;
            for (int i = 1; i <= 21; i++) begin
                expIrq[i] = 1'b0;
            end
            checkOutput("irqSequence", obs, expIrq);
        end
        @(posedge I_clk);
        #1;
        writeReg(A_CTRL, 32'h0, 4'b0001);
        repeat (2) @(posedge I_clk);
        #1;
        checkOutput("irqDisabled", O_irq, 1'b0);
        waitDrain(500);
`else
        readCheck("ctrlAbsent", A_CTRL, 32'h0);
        sendByte(8'h5A, 1'b1);
        waitDrain(500);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
